// File: rtl/peripheral_bridge_pkg.sv
// Shared types and constants for the APB4-slave to AHB3-Lite-master bridge.
// Contents: FSM state enum, HTRANS/HSIZE/HBURST encodings, HPROT reset value.
package peripheral_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [3:0] HPROT_RESET = 4'b0011;

endpackage

// File: rtl/peripheral_bridge_strb_decode.sv
// Combinational decode of an APB4 write strobe into an AHB transfer size and
// the low two address bits. Reads are always word sized at a word boundary.
// Ports:
//   pstrb   in  4  APB byte strobes
//   pwrite  in  1  APB direction, 1 = write
//   hsize   out 3  AHB transfer size
//   addr_lo out 2  AHB address bits [1:0]
//   illegal out 1  strobe pattern has no single AHB transfer equivalent
module peripheral_bridge_strb_decode
  import peripheral_bridge_pkg::*;
(
  input  logic [3:0] pstrb,
  input  logic       pwrite,
  output logic [2:0] hsize,
  output logic [1:0] addr_lo,
  output logic       illegal
);

  always_comb begin
    hsize   = HSIZE_WORD;
    addr_lo = 2'b00;
    illegal = 1'b0;
    if (pwrite) begin
      case (pstrb)
        4'b1111: begin hsize = HSIZE_WORD; addr_lo = 2'b00; end
        4'b0011: begin hsize = HSIZE_HALF; addr_lo = 2'b00; end
        4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
        4'b0001: begin hsize = HSIZE_BYTE; addr_lo = 2'b00; end
        4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
        4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
        4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bridge_apb4_ahb3_master.sv
// APB4 slave to AHB3-Lite master bridge. Each APB transfer is replayed as a
// single NONSEQ AHB transfer; one transfer outstanding, single clock domain.
// All outputs are registered.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   PSEL..PPROT                  APB4 request inputs
//   PRDATA, PREADY, PSLVERR      APB4 completion outputs
//   HADDR..HMASTLOCK             AHB3-Lite master request outputs
//   HRDATA, HREADY, HRESP        AHB3-Lite slave response inputs
//
// state | meaning
// IDLE  | waiting for an APB setup cycle
// ADDR  | AHB address phase, NONSEQ on the bus until HREADY
// DATA  | AHB data phase, waiting for HREADY to capture the response
// RESP  | PREADY pulse to the APB side, then back to IDLE
module peripheral_bridge_apb4_ahb3_master
  import peripheral_bridge_pkg::*;
#(
  parameter int HADDR_SIZE = 8,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [HADDR_SIZE-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [HDATA_SIZE-1:0] PWDATA,
  input  logic [3:0]            PSTRB,
  input  logic [2:0]            PPROT,
  output logic [HDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  bridge_state_e state_q, state_nxt;

  logic [HDATA_SIZE-1:0] wdata_q, wdata_nxt;
  logic [HDATA_SIZE-1:0] prdata_nxt, hwdata_nxt;
  logic [HADDR_SIZE-1:0] haddr_nxt;
  logic [2:0]            hsize_nxt;
  logic [3:0]            hprot_nxt;
  logic [1:0]            htrans_nxt;
  logic                  hwrite_nxt, pready_nxt, pslverr_nxt;

  logic [2:0] dec_hsize;
  logic [1:0] dec_addr_lo;
  logic       dec_illegal;

  // PADDR[1:0] is replaced by the strobe-derived offset; PPROT[1] has no AHB
  // counterpart.
  logic unused_bits;
  assign unused_bits = ^{PADDR[1:0], PPROT[1]};

  peripheral_bridge_strb_decode u_strb_decode (
    .pstrb   (PSTRB),
    .pwrite  (PWRITE),
    .hsize   (dec_hsize),
    .addr_lo (dec_addr_lo),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_nxt   = state_q;
    wdata_nxt   = wdata_q;
    prdata_nxt  = PRDATA;
    hwdata_nxt  = HWDATA;
    haddr_nxt   = HADDR;
    hsize_nxt   = HSIZE;
    hprot_nxt   = HPROT;
    htrans_nxt  = HTRANS;
    hwrite_nxt  = HWRITE;
    pready_nxt  = PREADY;
    pslverr_nxt = PSLVERR;

    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (dec_illegal) begin
            // No AHB transfer; complete the APB access with an error.
            state_nxt   = ST_RESP;
            pready_nxt  = 1'b1;
            pslverr_nxt = 1'b1;
          end else begin
            state_nxt  = ST_ADDR;
            htrans_nxt = HTRANS_NONSEQ;
            haddr_nxt  = {PADDR[HADDR_SIZE-1:2], dec_addr_lo};
            hsize_nxt  = dec_hsize;
            hwrite_nxt = PWRITE;
            hprot_nxt  = {2'b00, PPROT[0], ~PPROT[2]};
            if (PWRITE) wdata_nxt = PWDATA;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_nxt  = ST_DATA;
          htrans_nxt = HTRANS_IDLE;
          if (HWRITE) hwdata_nxt = wdata_q;
        end
      end
      ST_DATA: begin
        // The first ERROR cycle (HREADY=0) simply extends the wait; there is
        // never a following transfer to cancel.
        if (HREADY) begin
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = HRESP;
          if (!HWRITE) prdata_nxt = HRDATA;
        end
      end
      ST_RESP: begin
        state_nxt   = ST_IDLE;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      wdata_q   <= '0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      HADDR     <= '0;
      HWDATA    <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= HSIZE_WORD;
      HBURST    <= HBURST_SINGLE;
      HPROT     <= HPROT_RESET;
      HTRANS    <= HTRANS_IDLE;
      HMASTLOCK <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      wdata_q   <= wdata_nxt;
      PRDATA    <= prdata_nxt;
      PREADY    <= pready_nxt;
      PSLVERR   <= pslverr_nxt;
      HADDR     <= haddr_nxt;
      HWDATA    <= hwdata_nxt;
      HWRITE    <= hwrite_nxt;
      HSIZE     <= hsize_nxt;
      HBURST    <= HBURST_SINGLE;
      HPROT     <= hprot_nxt;
      HTRANS    <= htrans_nxt;
      HMASTLOCK <= 1'b0;
    end
  end

endmodule
